sqrt_arb: RTL and testbench

Round-robin arbiter sharing one pipelined fixed-point square-root unit among N requesters. Each cycle it grants at most one requester and registers that operand into the shared sqrt unit. It carries the requester ID through a tag pipe matched to the sqrt latency, so each result returns to the requester that issued it. It sits between matrix kernels (e.g. Cholesky and normalisation engines) and the single sqrt instance, so that expensive datapath is not duplicated.

---
 rtl/sqrt_arb.sv | 136 +++++++++++++
 tb/tb_sqrt_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arb.sv
// sqrt_arb: round-robin arbiter in front of one shared pipelined square-root unit.
// Grants at most one requester per cycle and registers its operand into the
// sqrt unit. A tag pipe as deep as the sqrt latency carries the requester ID,
// so each result is steered back to the requester that issued it.
// Build option: define SQRT_ARB_FIXED_PRIO_EN to pin the priority pointer at 0
// (fixed lowest-index-wins priority). Round-robin is used when it is undefined.
module sqrt_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 4
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               hold,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic [WIDTH-1:0]   sq_in,
  input  logic [WIDTH-1:0]   sq_out,
  output logic [N-1:0]       res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic               busy
);

  localparam int IDW = $clog2(N);
  typedef logic [IDW-1:0] id_t;

  // Pointer advance with an explicit wrap, since N need not be a power of 2.
  function automatic id_t f_next_ptr(input id_t id);
    if (int'(id) == N - 1) return '0;
    else                   return id + id_t'(1);
  endfunction

  function automatic logic [N-1:0] f_onehot(input id_t id);
    logic [N-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  id_t              r_ptr;
  logic             w_gnt;
  id_t              w_gnt_id;
  logic [N-1:0]     w_ready;

  logic             r_iss_v_p0;
  id_t              r_iss_id_p0;
  logic [WIDTH-1:0] r_sq_in_p0;

  logic [LAT-1:0]   r_tp_v;
  id_t              r_tp_id [LAT];

  logic [N-1:0]     r_res_valid_p1;
  logic [WIDTH-1:0] r_res_data_p1;

  // Pick the first valid requester at or after the pointer, scanning upward mod N.
  always_comb begin : p_grant
    int idx;
    idx      = 0;
    w_gnt    = 1'b0;
    w_gnt_id = '0;
    // Descending scan so the smallest offset from the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req_valid[id_t'(idx)]) begin
        w_gnt    = 1'b1;
        w_gnt_id = id_t'(idx);
      end
    end
    if (!reset_l || hold) w_gnt = 1'b0;
  end

  // Expand the granted index into the one-hot ready vector.
  always_comb begin
    w_ready = '0;
    if (w_gnt) w_ready = f_onehot(w_gnt_id);
  end

  assign req_ready = w_ready;

  // ---- issue stage: operand into the sqrt unit, tag and pointer update ----
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_ptr       <= '0;
      r_sq_in_p0  <= '0;
      r_iss_v_p0  <= 1'b0;
      r_iss_id_p0 <= '0;
    end else begin
      r_iss_v_p0 <= w_gnt;
      if (w_gnt) begin
        r_iss_id_p0 <= w_gnt_id;
        r_sq_in_p0  <= req_data[int'(w_gnt_id)*WIDTH +: WIDTH];
`ifdef SQRT_ARB_FIXED_PRIO_EN
        r_ptr <= '0;
`else
        r_ptr <= f_next_ptr(w_gnt_id);
`endif
      end
    end
  end

  assign sq_in = r_sq_in_p0;

  // ---- tag pipe: valid bits, cleared by reset so in-flight work is dropped ----
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_tp_v <= '0;
    end else begin
      r_tp_v[0] <= r_iss_v_p0;
      for (int k = 1; k < LAT; k++) r_tp_v[k] <= r_tp_v[k-1];
    end
  end

  // Tag pipe IDs only matter where the matching valid bit is set.
  always_ff @(posedge clk) begin
    r_tp_id[0] <= r_iss_id_p0;
    for (int k = 1; k < LAT; k++) r_tp_id[k] <= r_tp_id[k-1];
  end

  // ---- output stage: steer the aligned sqrt result to its requester ----
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_res_valid_p1 <= '0;
      r_res_data_p1  <= '0;
    end else begin
      r_res_data_p1  <= sq_out;
      r_res_valid_p1 <= r_tp_v[LAT-1] ? f_onehot(r_tp_id[LAT-1]) : '0;
    end
  end

  assign res_valid = r_res_valid_p1;
  assign res_data  = r_res_data_p1;
  assign busy      = r_iss_v_p0 | (|r_tp_v) | (|r_res_valid_p1);

endmodule

// File: tb/tb_sqrt_arb.sv
// Testbench for sqrt_arb (N=4, WIDTH=32, LAT=4) with a Q16.16 sqrt unit model.
// Per-cycle table of inputs and expected grant/busy; results checked through
// a scoreboard of expected {id, sqrt value, cycle}.
module tb_sqrt_arb;
  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int LAT   = 4;

  logic               clk = 1'b0;
  logic               reset_l;
  logic               hold;
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic [WIDTH-1:0]   sq_in;
  logic [WIDTH-1:0]   sq_out;
  logic [N-1:0]       res_valid;
  logic [WIDTH-1:0]   res_data;
  logic               busy;

  always #5 clk = ~clk;

  sqrt_arb #(.N(N), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .reset_l(reset_l), .hold(hold),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sq_in(sq_in), .sq_out(sq_out),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  // Q16.16 square root: floor(sqrt(x * 2^16)).
  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [63:0] v;
    logic [31:0] r;
    logic [31:0] c;
    v = {16'h0, x, 16'h0};
    r = '0;
    for (int b = 23; b >= 0; b--) begin
      c = r | (32'd1 << b);
      if ({32'd0, c} * {32'd0, c} <= v) r = c;
    end
    return r;
  endfunction

  // Sqrt unit model: LAT-cycle pipeline, never reset.
  logic [WIDTH-1:0] sp [LAT];
  always @(posedge clk) begin
    sp[0] <= isqrt(sq_in);
    for (int k = 1; k < LAT; k++) sp[k] <= sp[k-1];
  end
  assign sq_out = sp[LAT-1];

  int cyc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  typedef struct {
    logic         rst_n;
    logic         hold;
    logic [N-1:0] vld;
    logic [N-1:0] rdy;
    logic         busy;
    int           chk;   // 0 none, 1 all-zero state, 2 the 4.0 -> 2.0 result
  } row_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  row_t tbl[$];
  exp_t sbq[$];

  task automatic add(input int n, input logic rst_n, input logic h,
                     input logic [N-1:0] vld, input logic [N-1:0] rdy,
                     input logic b, input int chk);
    row_t r;
    r.rst_n = rst_n; r.hold = h; r.vld = vld; r.rdy = rdy; r.busy = b; r.chk = chk;
    for (int i = 0; i < n; i++) tbl.push_back(r);
  endtask

  // Result monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid != '0) begin
        if (sbq.size() == 0) begin
          check("res_unexpected", 64'(res_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          check("res_id", 64'(res_valid), 64'(onehot(e.id)));
          check("res_data", 64'(res_data), 64'(e.data));
          check("res_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("res_missing", 64'(res_valid), 64'(onehot(e.id)));
      end
    end
  end

  logic [31:0] d [N];

  initial begin
    int gid;
    reset_l   = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    d[0] = 32'h0004_0000;
    d[1] = 32'h0009_0000;
    d[2] = 32'hFFFF_FFFF;
    d[3] = 32'h0000_0001;

`ifdef SQRT_ARB_FIXED_PRIO_EN
    add(2, 0, 0, 4'b1111, 4'b0000, 0, 1);
    add(3, 1, 0, 4'b0000, 4'b0000, 0, 0);
    add(1, 1, 0, 4'b0011, 4'b0001, 0, 0);
    add(7, 1, 0, 4'b0011, 4'b0001, 1, 0);
    add(6, 1, 0, 4'b0000, 4'b0000, 1, 0);
    add(1, 1, 0, 4'b0000, 4'b0000, 0, 0);
`else
    // reset state with requests pending, then idle
    add(2, 0, 0, 4'b1111, 4'b0000, 0, 1);
    add(8, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // single request of 4.0 at cycle 10, result 2.0 at cycle 16
    add(1, 1, 0, 4'b0001, 4'b0001, 0, 0);
    add(5, 1, 0, 4'b0000, 4'b0000, 1, 0);
    add(1, 1, 0, 4'b0000, 4'b0000, 1, 2);
    add(2, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // ptr=1: grant 3, then 1010 from ptr 0, wrap 3 -> 0
    add(1, 1, 0, 4'b1000, 4'b1000, 0, 0);
    add(1, 1, 0, 4'b1010, 4'b0010, 1, 0);
    add(1, 1, 0, 4'b1010, 4'b1000, 1, 0);
    add(1, 1, 0, 4'b0011, 4'b0001, 1, 0);
    add(1, 1, 0, 4'b0010, 4'b0010, 1, 0);
    add(6, 1, 0, 4'b0000, 4'b0000, 1, 0);
    add(1, 1, 0, 4'b0000, 4'b0000, 0, 0);
    // reset, then all four continuously valid
    add(1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(1, 1, 0, 4'b1111, 4'b0001, 0, 1);
    add(1, 1, 0, 4'b1111, 4'b0010, 1, 0);
    add(1, 1, 0, 4'b1111, 4'b0100, 1, 0);
    add(1, 1, 0, 4'b1111, 4'b1000, 1, 0);
    add(1, 1, 0, 4'b1111, 4'b0001, 1, 0);
    add(1, 1, 0, 4'b1111, 4'b0010, 1, 0);
    // hold: no grants, in-flight results still arrive, pointer kept
    add(6, 1, 1, 4'b1111, 4'b0000, 1, 0);
    add(1, 1, 1, 4'b1111, 4'b0000, 0, 0);
    add(1, 1, 0, 4'b1111, 4'b0100, 0, 0);
    add(1, 1, 0, 4'b1111, 4'b1000, 1, 0);
    // reset 2 cycles after a grant discards both in-flight operations
    add(1, 1, 0, 4'b0000, 4'b0000, 1, 0);
    add(1, 0, 0, 4'b0110, 4'b0000, 1, 0);
    add(1, 1, 0, 4'b0110, 4'b0010, 0, 1);
    add(1, 1, 0, 4'b0100, 4'b0100, 1, 0);
    add(6, 1, 0, 4'b0000, 4'b0000, 1, 0);
    add(2, 1, 0, 4'b0000, 4'b0000, 0, 0);
`endif

    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk);
      #1;
      reset_l   = tbl[r].rst_n;
      hold      = tbl[r].hold;
      req_valid = tbl[r].vld;
      for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = d[i];
      if (!tbl[r].rst_n) begin
        for (int j = sbq.size() - 1; j >= 0; j--)
          if (sbq[j].due > cyc) sbq.delete(j);
      end
      gid = -1;
      for (int i = 0; i < N; i++) if (tbl[r].rdy[i]) gid = i;
      if (gid >= 0) begin
        exp_t e;
        e.id = gid; e.data = isqrt(d[gid]); e.due = cyc + 2 + LAT;
        sbq.push_back(e);
      end
      @(negedge clk);
      check("req_ready", 64'(req_ready), 64'(tbl[r].rdy));
      check("busy", 64'(busy), 64'(tbl[r].busy));
      if (tbl[r].chk == 1) begin
        check("zero_sq_in", 64'(sq_in), 64'(0));
        check("zero_res_data", 64'(res_data), 64'(0));
        check("zero_res_valid", 64'(res_valid), 64'(0));
      end
      if (tbl[r].chk == 2) begin
        check("sqrt4_valid", 64'(res_valid), 64'(4'b0001));
        check("sqrt4_data", 64'(res_data), 64'(32'h0002_0000));
      end
      if (gid >= 0) d[gid] = d[gid] * 32'h41C6_4E6D + 32'h0000_3039;
    end

    for (int w = 0; w < 20; w++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
